mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: datapath width of source_1, source_2, alu_result, mem_rdata, mem_wdata and result.
REQ-002 Parameter ADDR_W, default 16: memory address width; the address is taken from the low ADDR_W bits of its source.
REQ-003 Parameter TIMEOUT, default 15: maximum number of cycles to wait for mem_ack (minimum 1).
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port reset_n, input, 1: synchronous, active-low reset.
REQ-006 Port req_valid / req_ready, input / output, 1 / 1: request handshake; a request is accepted when both are 1 on a rising edge.
REQ-007 Port op_code, input, 4: operation code; 4'b1001 is LDR, 4'b1010 is STR, and every other value is non-memory (NOP).
REQ-008 Ports source_1, source_2, alu_result, input, DATA_W each: address source, store data and ALU result.
REQ-009 Port pc_addr, input, ADDR_W: address driven onto mem_addr while idle.
REQ-010 Ports mem_en, mem_we, output, 1 each: memory strobe and write enable (1 = write).
REQ-011 Ports mem_addr / mem_wdata, output, ADDR_W / DATA_W: memory address and store data.
REQ-012 Ports mem_rdata / mem_ack, input, DATA_W / 1: read data and access-complete strobe.
REQ-013 Ports result / result_valid / err, output, DATA_W / 1 / 1: write-back value, its one-cycle valid pulse, and the timeout flag.

Function
REQ-014 The FSM SHALL have four states: IDLE, ACCESS, WAIT and RESP.
REQ-015 In IDLE: req_ready=1 and mem_addr=pc_addr.
- An accepted LDR or STR goes to ACCESS.
- An accepted NOP latches alu_result and goes to RESP.
REQ-016 On acceptance, the block SHALL register op_code, source_1[ADDR_W-1:0] and source_2; later input changes have no effect.
REQ-017 In ACCESS: mem_en=1, mem_we=1 only for STR, mem_addr=latched address, mem_wdata=latched source_2.
- On mem_ack, go to RESP.
- Otherwise go to WAIT.
REQ-018 In WAIT, the block SHALL hold all mem_* outputs and count cycles.
- On mem_ack, go to RESP.
- On the TIMEOUT-th WAIT cycle without mem_ack, set err=1 and go to RESP.
REQ-019 The result SHALL be latched as follows:
- LDR: mem_rdata in the mem_ack cycle.
- STR: latched source_2.
- NOP: alu_result.
- Timeout: all zeros.
REQ-020 RESP SHALL last exactly one cycle with result_valid=1, then go to IDLE; result holds its value until the next RESP.
REQ-021 err SHALL stay 1 until the next accepted request clears it.
REQ-022 req_ready SHALL be 0 in ACCESS, WAIT and RESP; req_valid in those states is ignored and is not queued.
REQ-023 Latency from acceptance to result_valid:
- NOP: 1 cycle.
- Memory op with mem_ack in the ACCESS cycle: 2 cycles.
- Otherwise: 2 + number of WAIT cycles.
REQ-024 mem_ack outside ACCESS or WAIT SHALL be ignored.
REQ-025 mem_en SHALL be 0 in IDLE and RESP.
REQ-026 The WAIT cycle counter SHALL be sized as clog2(TIMEOUT+1) bits, SHALL saturate at TIMEOUT and SHALL not wrap.

Reset
REQ-027 With reset_n=0 at a clock edge, the block SHALL go to IDLE and clear these to 0: mem_en, mem_we, result_valid, err, result, the counter and all latched registers.
REQ-028 Reset SHALL take priority over every other event, including mid-access; an in-flight access is abandoned with no result_valid.
REQ-029 During reset, req_ready SHALL read 0 and mem_addr SHALL read pc_addr.

Structure
REQ-030 The opcode constants (LDR_OP, STR_OP) and the state encoding enum SHALL live in the shared package cpu_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; the result select is inline.

Verification
REQ-032 LDR, source_1=32'h0000_0040, mem_ack in the ACCESS cycle, mem_rdata=32'hDEAD_BEEF -> mem_addr=16'h0040 and mem_we=0; result=32'hDEAD_BEEF with result_valid 2 cycles after acceptance.
REQ-033 STR, source_1=16'h0010, source_2=32'h1234_5678, mem_ack after 3 WAIT cycles -> mem_we=1 and mem_wdata held stable; result_valid at cycle 5.
REQ-034 op_code=4'b0010, alu_result=32'h0000_0007 -> no mem_en; result=7 with result_valid 1 cycle after acceptance.
REQ-035 LDR with TIMEOUT=4 and no mem_ack -> err=1, result=0; result_valid at cycle 6; err cleared on the next acceptance.
REQ-036 reset_n=0 in WAIT -> IDLE next cycle, mem_en=0, no result_valid; a following LDR completes normally.
REQ-037 req_valid held at 1 through RESP -> exactly one acceptance per completed request; the second acceptance occurs in the cycle after RESP.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory opcodes and the access-controller state encoding.
package cpu_pkg;

    localparam logic [3:0] LDR_OP = 4'b1001;
    localparam logic [3:0] STR_OP = 4'b1010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Load/store memory access controller: one request at a time, bounded wait for
// mem_ack, single-cycle result pulse with a sticky timeout flag.
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        op_code,
    input  logic [DATA_W-1:0] source_1,
    input  logic [DATA_W-1:0] source_2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t              r_state;
    logic [3:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_src2;
    logic [DATA_W-1:0]   r_result;
    logic                r_result_valid;
    logic                r_err;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [CNT_W-1:0]    r_cnt;

    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_is_mem;

    always_comb begin
        w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        w_is_mem   = (op_code == LDR_OP) || (op_code == STR_OP);
    end

    // Ready and the idle address follow reset_n directly so both are correct during reset.
    assign req_ready    = reset_n && (r_state == IDLE);
    assign mem_addr     = (!reset_n || r_state == IDLE) ? pc_addr : r_addr;
    assign mem_en       = r_mem_en;
    assign mem_we       = r_mem_we;
    assign mem_wdata    = r_src2;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign err          = r_err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_op           <= '0;
            r_addr         <= '0;
            r_src2         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_mem_en       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_cnt          <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op   <= op_code;
                        r_addr <= source_1[ADDR_W-1:0];
                        r_src2 <= source_2;
                        r_err  <= 1'b0;
                        r_cnt  <= '0;
                        if (w_is_mem) begin
                            r_mem_en <= 1'b1;
                            r_mem_we <= (op_code == STR_OP);
                            r_state  <= ACCESS;
                        end else begin
                            r_result       <= alu_result;
                            r_result_valid <= 1'b1;
                            r_state        <= RESP;
                        end
                    end
                end
                // ACCESS and WAIT share completion; they differ only in how a missing ack is handled.
                ACCESS, WAIT: begin
                    if (mem_ack) begin
                        r_result       <= (r_op == LDR_OP) ? mem_rdata : r_src2;
                        r_result_valid <= 1'b1;
                        r_mem_en       <= 1'b0;
                        r_mem_we       <= 1'b0;
                        r_state        <= RESP;
                    end else if (r_state == ACCESS) begin
                        r_state <= WAIT;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == CNT_MAX) begin
                            r_result       <= '0;
                            r_result_valid <= 1'b1;
                            r_err          <= 1'b1;
                            r_mem_en       <= 1'b0;
                            r_mem_we       <= 1'b0;
                            r_state        <= RESP;
                        end
                    end
                end
                RESP: begin
                    r_result_valid <= 1'b0;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver predicts each request's result,
// error flag and completion cycle; a monitor checks them whenever result_valid fires.
module tb_mem_access_ctrl;
    import cpu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    op_code;
    logic [DW-1:0] source_1, source_2, alu_result, mem_rdata, mem_wdata, result;
    logic [AW-1:0] pc_addr, mem_addr;
    logic          mem_en, mem_we, mem_ack, result_valid, err;

    mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .op_code(op_code), .source_1(source_1), .source_2(source_2),
        .alu_result(alu_result), .pc_addr(pc_addr), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .result(result), .result_valid(result_valid), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] res;
        logic          err;
        int unsigned   when;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n === 1'b1 && result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result_valid @cycle %0d: actual=1 expected=0", cyc);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("err_at_result", err, e.err);
                chk("result_cycle", cyc, e.when);
            end
        end
    end

    task automatic scramble();
        req_valid  = 1'($urandom);
        op_code    = 4'($urandom);
        source_1   = $urandom;
        source_2   = $urandom;
        alu_result = $urandom;
        pc_addr    = 16'($urandom);
    endtask

    // Entered and left at a negedge while the DUT is idle. d = ack cycle index
    // (0 = ACCESS cycle, k = k-th WAIT cycle); d > TO means no ack at all.
    task automatic txn(input logic [3:0] op, input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                       input logic [DW-1:0] alu, input logic [DW-1:0] rd, input int unsigned d);
        logic          is_mem, is_str, timed_out;
        int unsigned   last, lat;
        logic [DW-1:0] res;
        logic [AW-1:0] a;
        is_mem    = (op == 4'b1001) || (op == 4'b1010);
        is_str    = (op == 4'b1010);
        last      = (d <= TO) ? d : TO;
        timed_out = is_mem && (d > TO);
        lat       = is_mem ? 2 + last : 1;
        res       = !is_mem ? alu : timed_out ? '0 : is_str ? s2 : rd;
        a         = s1[AW-1:0];

        pc_addr = 16'($urandom);
        op_code = op; source_1 = s1; source_2 = s2; alu_result = alu;
        req_valid = 1'b1;
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        #1;
        chk("idle_ready", req_ready, 1);
        chk("idle_addr", mem_addr, pc_addr);
        chk("idle_mem_en", mem_en, 0);
        sb.push_back('{res: res, err: timed_out, when: cyc + lat});
        @(posedge clk);
        @(negedge clk);
        if (is_mem) begin
            for (int unsigned k = 0; k <= last; k++) begin
                scramble();
                chk("busy_ready", req_ready, 0);
                chk("mem_en", mem_en, 1);
                chk("mem_we", mem_we, is_str);
                chk("mem_addr", mem_addr, a);
                chk("mem_wdata", mem_wdata, s2);
                if (k == 0) chk("err_cleared", err, 0);
                mem_ack   = (k == d);
                mem_rdata = (k == d) ? rd : $urandom;
                @(negedge clk);
            end
        end else begin
            chk("nop_err_cleared", err, 0);
        end
        scramble();
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        chk("resp_ready", req_ready, 0);
        chk("resp_mem_en", mem_en, 0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("err_hold", err, timed_out);
        chk("result_hold", result, res);
    endtask

    task automatic idle_gap(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            req_valid = 1'b0;
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
            pc_addr   = 16'($urandom);
            #1;
            chk("gap_ready", req_ready, 1);
            chk("gap_addr", mem_addr, pc_addr);
            chk("gap_mem_en", mem_en, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] op;
        reset_n = 1'b0; req_valid = 1'b0; op_code = '0; mem_ack = 1'b0;
        source_1 = '0; source_2 = '0; alu_result = '0; mem_rdata = '0;
        pc_addr = 16'h1234;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_addr", mem_addr, 16'h1234);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        reset_n = 1'b1;
        @(negedge clk);

        txn(LDR_OP, 32'h0000_0040, $urandom, $urandom, 32'hDEAD_BEEF, 0);
        txn(STR_OP, 32'h0000_0010, 32'h1234_5678, $urandom, $urandom, 3);
        txn(4'b0010, $urandom, $urandom, 32'h0000_0007, $urandom, 0);
        txn(LDR_OP, $urandom, $urandom, $urandom, $urandom, TO + 1);
        txn(STR_OP, $urandom, $urandom, $urandom, $urandom, TO);
        txn(LDR_OP, $urandom, $urandom, $urandom, $urandom, 1);

        // Reset while waiting: the access is dropped and no result appears.
        pc_addr = 16'($urandom); op_code = LDR_OP; source_1 = 32'h0000_0123;
        req_valid = 1'b1; mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("wait_mem_en", mem_en, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_addr", mem_addr, pc_addr);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_result", result, 0);
        reset_n = 1'b1;
        @(negedge clk);
        txn(LDR_OP, $urandom, $urandom, $urandom, $urandom, 0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom % 4)
                0: op = LDR_OP;
                1: op = STR_OP;
                default: begin
                    op = 4'($urandom);
                    if (op == LDR_OP || op == STR_OP) op = 4'b0000;
                end
            endcase
            txn(op, $urandom, $urandom, $urandom, $urandom, $urandom_range(0, TO + 1));
            idle_gap($urandom_range(0, 2));
        end

        idle_gap(3);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
